dup_range_gen: RTL and testbench

Streaming generator that walks a signed arithmetic range and emits every element twice, one value per accepted transfer. A start pulse captures `base`, `limit` and `step`. The block then produces `base, base, base+step, base+step, …` for as long as the element is `< limit`. It sits as a leaf producer behind a valid/ready consumer and wraps one `hrange` pair-generator sub-module.

---
 rtl/dup_range_pkg.sv | 20 ++
 rtl/dup_range_gen_hrange.sv | 67 ++++++
 rtl/dup_range_gen.sv | 104 ++++++++++
 tb/tb_dup_range_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dup_range_pkg.sv
// Shared constants and state encodings for the duplicating range generator
// and its hrange pair source.
package dup_range_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_FIRST,
        GEN_SECOND,
        GEN_DONE
    } gen_state_t;

    typedef enum logic [1:0] {
        HR_IDLE,
        HR_EMIT,
        HR_DONE
    } hr_state_t;

endpackage

// File: rtl/dup_range_gen_hrange.sv
// hrange: walks i = base; i < limit; i += step (signed, wrapping) and offers
// each element as the pair (i, i) on a valid/ready handshake.
module hrange
    import dup_range_pkg::*;
(
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic                     _start,
    input  logic                     _ready,
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] limit,
    input  logic signed [DATA_W-1:0] step,
    output logic                     _done,
    output logic                     _valid,
    output logic signed [DATA_W-1:0] _0,
    output logic signed [DATA_W-1:0] _1
);

    hr_state_t                state_q;
    hr_state_t                state_d;
    logic signed [DATA_W-1:0] i_q;
    logic signed [DATA_W-1:0] lim_q;
    logic signed [DATA_W-1:0] stp_q;
    logic signed [DATA_W-1:0] i_next;

    assign i_next = i_q + stp_q;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q <= HR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Argument capture and element advance.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            i_q   <= '0;
            lim_q <= '0;
            stp_q <= '0;
        end else if (_start) begin
            i_q   <= base;
            lim_q <= limit;
            stp_q <= step;
        end else if (state_q == HR_EMIT && _ready) begin
            i_q <= i_next;
        end
    end

    always_comb begin
        state_d = state_q;
        if (_start) begin
            state_d = (base < limit) ? HR_EMIT : HR_DONE;
        end else if (state_q == HR_EMIT && _ready) begin
            state_d = (i_next < lim_q) ? HR_EMIT : HR_DONE;
        end
    end

    always_comb begin
        _valid = (state_q == HR_EMIT);
        _done  = (state_q == HR_DONE);
        _0     = i_q;
        _1     = i_q;
    end

endmodule

// File: rtl/dup_range_gen.sv
// dup_range_gen: emits every element of a signed arithmetic range twice,
// using hrange as the pair source and consuming a pair only in SECOND.
module dup_range_gen
    import dup_range_pkg::*;
(
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic                     _start,
    input  logic                     _ready,
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] limit,
    input  logic signed [DATA_W-1:0] step,
    output logic                     _done,
    output logic                     _valid,
    output logic signed [DATA_W-1:0] _0
);

    gen_state_t               state_q;
    gen_state_t               state_d;
    logic                     hr_ready;
    logic                     hr_done;
    logic                     hr_valid;
    logic signed [DATA_W-1:0] hr_0;
    logic signed [DATA_W-1:0] hr_1;

    // Advancing hrange on the edge that consumes the second copy makes the
    // next element appear straight away, so there is no bubble between pairs.
    assign hr_ready = (state_q == GEN_SECOND) && _ready;

    hrange u_hrange (
        ._clock (_clock),
        ._reset (_reset),
        ._start (_start),
        ._ready (hr_ready),
        .base   (base),
        .limit  (limit),
        .step   (step),
        ._done  (hr_done),
        ._valid (hr_valid),
        ._0     (hr_0),
        ._1     (hr_1)
    );

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q <= GEN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE also covers the one cycle hrange needs to evaluate a fresh start.
    always_comb begin
        state_d = state_q;
        if (_start) begin
            state_d = GEN_IDLE;
        end else begin
            unique case (state_q)
                GEN_IDLE: begin
                    if (hr_valid) begin
                        state_d = GEN_FIRST;
                    end else if (hr_done) begin
                        state_d = GEN_DONE;
                    end
                end
                GEN_FIRST: begin
                    if (hr_done) begin
                        state_d = GEN_DONE;
                    end else if (_ready) begin
                        state_d = GEN_SECOND;
                    end
                end
                GEN_SECOND: begin
                    if (_ready) begin
                        state_d = GEN_FIRST;
                    end
                end
                GEN_DONE: state_d = GEN_DONE;
                default:  state_d = GEN_IDLE;
            endcase
        end
    end

    // FIRST with hrange exhausted is the completion cycle: done, not valid.
    always_comb begin
        _valid = 1'b0;
        _done  = 1'b0;
        _0     = '0;
        unique case (state_q)
            GEN_FIRST: begin
                _valid = hr_valid;
                _done  = hr_done;
                _0     = hr_valid ? hr_0 : '0;
            end
            GEN_SECOND: begin
                _valid = hr_valid;
                _0     = hr_valid ? hr_1 : '0;
            end
            GEN_DONE: _done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dup_range_gen.sv
// Randomized self-checking bench for dup_range_gen against a queue model of
// the doubled range.
module tb_dup_range_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               ready;
    logic signed [31:0] base;
    logic signed [31:0] limit;
    logic signed [31:0] step;
    logic               done;
    logic               valid;
    logic signed [31:0] dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dup_range_gen dut (
        ._clock (clk),
        ._reset (rst),
        ._start (start),
        ._ready (ready),
        .base   (base),
        .limit  (limit),
        .step   (step),
        ._done  (done),
        ._valid (valid),
        ._0     (dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    // Start a run, then consume until done (or until stop_after elements have
    // been handed over). rnd selects pseudo-random backpressure.
    task automatic run(input int b, input int l, input int s, input bit rnd, input int stop_after);
        int         q[$];
        int         v;
        int         consumed;
        int         budget;
        int         e;
        bit         held;
        bit         fin;
        logic [31:0] held_v;

        v = b;
        while (v < l && q.size() < 200) begin
            q.push_back(v);
            q.push_back(v);
            v = v + s;
        end

        @(negedge clk);
        base  = b;
        limit = l;
        step  = s;
        start = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        base  = $urandom;
        limit = $urandom;
        step  = $urandom;
        check("start_clr_done", {31'd0, done}, 0);
        check("start_no_valid", {31'd0, valid}, 0);
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

        @(negedge clk);
        check("first_valid", {31'd0, valid}, (q.size() != 0) ? 1 : 0);
        check("first_done", {31'd0, done}, (q.size() == 0) ? 1 : 0);

        budget   = 8 * q.size() + 20;
        fin      = 1'b0;
        held     = 1'b0;
        consumed = 0;
        for (int k = 0; k < budget && !fin; k++) begin
            if (k > 0) @(negedge clk);
            check("valid_done_excl", {31'd0, valid & done}, 0);
            if (held) begin
                check("stall_valid", {31'd0, valid}, 1);
                check("stall_hold", dout, held_v);
            end
            if (done) begin
                check("done_drained", q.size(), 0);
                held = 1'b0;
                fin  = 1'b1;
            end else if (valid) begin
                ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (ready) begin
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("data", dout, e);
                    end else begin
                        check("data_extra", {31'd0, valid}, 0);
                    end
                    held = 1'b0;
                    consumed++;
                    if (consumed == stop_after) fin = 1'b1;
                end else begin
                    held   = 1'b1;
                    held_v = dout;
                end
            end else begin
                held  = 1'b0;
                ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        check("timeout", {31'd0, fin}, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        base  = '0;
        limit = '0;
        step  = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_data", dout, 0);
        rst   = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check("idle_valid", {31'd0, valid}, 0);
        check("idle_done", {31'd0, done}, 0);

        // Directed: nominal, back-to-back, empty ranges, backpressure, boundaries.
        run(0, 10, 2, 1'b0, 0);
        run(0, 10, 2, 1'b0, 0);
        run(5, 5, 1, 1'b0, 0);
        run(7, 3, 1, 1'b0, 0);
        run(0, 10, 2, 1'b1, 0);
        run(0, 6, 3, 1'b0, 0);
        run(0, 10, 100, 1'b0, 0);
        run(-10, -2, 3, 1'b1, 0);

        // Reset after the third element, then a clean rerun.
        run(0, 10, 2, 1'b0, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", {31'd0, valid}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_data", dout, 0);
        rst = 1'b0;
        run(0, 10, 2, 1'b0, 0);

        // Restart while busy: only the new run's elements may appear.
        run(0, 10, 2, 1'b1, 3);
        run(-3, 4, 1, 1'b1, 0);

        for (int t = 0; t < 25; t++) begin
            run(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
                int'($urandom_range(1, 6)), 1'b1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
